memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 33 +++
 tb/tb_memory.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// rtl/memory.sv - DEPTH x DATA_W RAM: one synchronous write port, one combinational read port,
// synchronous clear of every location on rst.
module memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              write_en,
    input  logic              clk,
    input  logic [ADDR_W-1:0] maddr,
    input  logic [ADDR_W-1:0] laddr,
    input  logic [DATA_W-1:0] val,
    output logic [DATA_W-1:0] dout,
    input  logic              rst
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[maddr] <= val;
        end
    end

    // Read straight from the array: a same-address write only shows after the edge.
    assign dout = mem_q[laddr];

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for memory
module tb_memory;

    logic       write_en;
    logic       clk;
    logic [7:0] maddr;
    logic [7:0] laddr;
    logic [7:0] val;
    logic [7:0] dout;
    logic       rst;

    int checks = 0;
    int errors = 0;

    memory #(.DATA_W(8), .ADDR_W(8)) dut (
        .write_en(write_en),
        .clk     (clk),
        .maddr   (maddr),
        .laddr   (laddr),
        .val     (val),
        .dout    (dout),
        .rst     (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; write_en = 1'b0; maddr = '0; val = '0; laddr = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            laddr = 8'(i);
            #1;
            checks++;
            if (dout !== 8'h00) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d dout=%h expected=00", i, dout);
            end
        end
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        write_en = 1'b1; maddr = 8'd0; val = 8'd69; laddr = 8'd5;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL basic_indep_read dout=%h expected=00", dout);
        end
        @(negedge clk);
        write_en = 1'b0; laddr = 8'd0;
        #1;
        checks++;
        if (dout !== 8'd69) begin
            errors++;
            $display("FAIL basic_addr0 dout=%h expected=%h", dout, 8'd69);
        end
        laddr = 8'd5;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL basic_addr5 dout=%h expected=00", dout);
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        write_en = 1'b1; maddr = 8'd3; val = 8'hAA; laddr = 8'd3;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL same_addr_before dout=%h expected=00", dout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'hAA) begin
            errors++;
            $display("FAIL same_addr_after dout=%h expected=aa", dout);
        end
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            write_en = 1'b1; maddr = 8'(i); val = 8'(i + 1);
        end
        @(negedge clk);
        write_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            laddr = 8'(i);
            #1;
            checks++;
            if (dout !== 8'(i + 1)) begin
                errors++;
                $display("FAIL fill_read addr=%0d dout=%h expected=%h", i, dout, 8'(i + 1));
            end
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            write_en = 1'b0; maddr = 8'(c * 37); val = 8'(8'hF0 ^ c);
        end
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            laddr = 8'(i);
            #1;
            checks++;
            if (dout !== 8'(i + 1)) begin
                errors++;
                $display("FAIL hold_read addr=%0d dout=%h expected=%h", i, dout, 8'(i + 1));
            end
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        write_en = 1'b1; maddr = 8'd7; val = 8'h55; laddr = 8'd7;
        @(negedge clk);
        write_en = 1'b1; maddr = 8'd7; val = 8'h11; rst = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h55) begin
            errors++;
            $display("FAIL rst_pending dout=%h expected=55", dout);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_priority dout=%h expected=00", dout);
        end
        laddr = 8'd100;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_clears_other dout=%h expected=00", dout);
        end
        @(negedge clk);
        rst = 1'b0; write_en = 1'b0;
        @(negedge clk);
        laddr = 8'd7;
        #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_no_late_write dout=%h expected=00", dout);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        write_en = 1'b1; maddr = 8'd200; val = 8'h3C;
        @(negedge clk);
        maddr = 8'd201; val = 8'hC3;
        @(negedge clk);
        maddr = 8'd255; val = 8'h7E;
        @(negedge clk);
        write_en = 1'b0;
        laddr = 8'd200; #1;
        checks++;
        if (dout !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_200 dout=%h expected=3c", dout);
        end
        laddr = 8'd201; #1;
        checks++;
        if (dout !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_201 dout=%h expected=c3", dout);
        end
        laddr = 8'd255; #1;
        checks++;
        if (dout !== 8'h7E) begin
            errors++;
            $display("FAIL b2b_255 dout=%h expected=7e", dout);
        end
        laddr = 8'd202; #1;
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL b2b_untouched dout=%h expected=00", dout);
        end
    endtask

    initial begin
        rst = 1'b1; write_en = 1'b0; maddr = '0; laddr = '0; val = '0;
        test_reset();
        test_basic_write();
        test_same_addr();
        test_reset();
        test_fill();
        test_hold();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
